sram_march_bist: RTL and testbench

- Built-in self-test engine that sits directly upstream of an OpenRAM single-port SRAM macro (CSb/WEb/OEb/ADDR/DATA/clk interface, e.g. the 2-bit x 16-word freepdk45 instance).
- Drives the macro's control, address and write-data pins with a March C- sequence.
- Captures read data and checks it against expected values.
- Reports pass/fail plus the first failing location.
- The bidirectional DATA pin is split into separate write-data, output-enable and read-data signals; the tristate buffer lives in the top-level wrapper.

---
 rtl/sram_bist_pkg.sv | 51 +++++
 rtl/sram_bist_checker.sv | 89 ++++++++
 rtl/sram_march_bist.sv | 191 +++++++++++++++++++
 tb/tb_sram_march_bist.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg
//   Shared types and the March C- element table for the SRAM BIST engine.
//   Contents:
//     op_t      - the four SRAM operations (write/read of pattern 0/1)
//     state_t   - sequencer states
//     NUM_ELEM  - number of march elements
//     ELEM_DOWN / ELEM_TWO_OPS / elem_op - element table (direction, op count, op list)
package sram_bist_pkg;

    typedef enum logic [1:0] {
        OP_W0 = 2'd0,
        OP_W1 = 2'd1,
        OP_R0 = 2'd2,
        OP_R1 = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ELEM = 6;

    // Bit e set: element e walks addresses N-1..0 (otherwise 0..N-1).
    localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b011000;
    // Bit e set: element e performs two ops per address (otherwise one).
    localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;

    // Op list: 'second' selects the second op of a two-op element.
    function automatic op_t elem_op(input logic [2:0] elem, input logic second);
        case (elem)
            3'd0:    return OP_W0;
            3'd1:    return second ? OP_W1 : OP_R0;
            3'd2:    return second ? OP_W0 : OP_R1;
            3'd3:    return second ? OP_W1 : OP_R0;
            3'd4:    return second ? OP_W0 : OP_R1;
            default: return OP_R0;
        endcase
    endfunction

    function automatic logic op_is_read(input op_t op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    function automatic logic op_value(input op_t op);
        return (op == OP_W1) || (op == OP_R1);
    endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// sram_bist_checker
//   Delays each issued read by READ_LATENCY cycles, compares the SRAM read
//   data with the expected pattern and latches the first failing location.
//   Ports:
//     clk, rst        - clock, synchronous active-high reset
//     i_clear         - clears the sticky fail state (new test started)
//     i_rd_vld        - a read command is on the SRAM pins this cycle
//     i_rd_exp        - expected data for that read
//     i_rd_addr       - address of that read
//     i_rd_elem       - march element of that read
//     i_rdata         - SRAM read data
//     o_fail          - sticky mismatch flag
//     o_fail_addr/elem/data - location and value of the first mismatch
module sram_bist_checker #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_rd_vld,
    input  logic [DATA_WIDTH-1:0] i_rd_exp,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [2:0]            i_rd_elem,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_fail,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [2:0]            o_fail_elem,
    output logic [DATA_WIDTH-1:0] o_fail_data
);

    logic                  r_vld_p  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_exp_p  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] r_addr_p [READ_LATENCY];
    logic [2:0]            r_elem_p [READ_LATENCY];

    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_elem;
    logic [DATA_WIDTH-1:0] r_fail_data;

    logic                  w_mismatch;

    // Pipe stage 0 captures the command as the SRAM samples it; the last
    // stage lines up with the cycle the SRAM presents the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) r_vld_p[i] <= 1'b0;
        end else begin
            r_vld_p[0] <= i_rd_vld;
            for (int i = 1; i < READ_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_exp_p[0]  <= i_rd_exp;
        r_addr_p[0] <= i_rd_addr;
        r_elem_p[0] <= i_rd_elem;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_exp_p[i]  <= r_exp_p[i-1];
            r_addr_p[i] <= r_addr_p[i-1];
            r_elem_p[i] <= r_elem_p[i-1];
        end
    end

    assign w_mismatch = r_vld_p[READ_LATENCY-1] && (i_rdata != r_exp_p[READ_LATENCY-1]);

    // Compare / first-fail capture
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_data <= '0;
        end else if (w_mismatch && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_addr_p[READ_LATENCY-1];
            r_fail_elem <= r_elem_p[READ_LATENCY-1];
            r_fail_data <= i_rdata;
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_elem = r_fail_elem;
    assign o_fail_data = r_fail_data;

endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist
//   March C- BIST sequencer for a single-port OpenRAM macro. Issues one SRAM
//   op per cycle (10N ops), then drains the read pipe and reports pass/fail.
//   Ports:
//     clk, rst            - clock shared with the SRAM, sync active-high reset
//     start               - one-cycle run request (honoured in IDLE/DONE)
//     busy, done          - run status
//     fail, fail_addr, fail_elem, fail_data - first-mismatch report
//     sram_csb/web/oeb    - active-low SRAM controls
//     sram_addr, sram_wdata, sram_data_oe - address, write data, DATA drive enable
//     sram_rdata          - DATA bus as seen by the BIST
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_data_oe,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
    localparam logic [2:0]            LAST_ELEM  = 3'(NUM_ELEM - 1);
    localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t                r_state, w_state;
    logic [2:0]            r_elem,  w_elem;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr;
    logic                  r_opi,   w_opi;
    logic [1:0]            r_drain, w_drain;
    logic                  r_busy,  w_busy;
    logic                  r_done,  w_done;
    op_t                   r_op,    w_op;

    logic                  r_csb, r_web, r_oeb, r_data_oe;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_issue, w_clear, w_down, w_op_end, w_addr_end, w_seq_end;
    logic w_write, w_read, w_rd_vld;

    // Next-state: counters always describe the op that will be on the pins
    // after the next edge.
    always_comb begin
        w_state  = r_state;
        w_elem   = r_elem;
        w_addr   = r_addr;
        w_opi    = r_opi;
        w_drain  = r_drain;
        w_busy   = r_busy;
        w_done   = r_done;
        w_clear  = 1'b0;
        w_issue  = 1'b0;

        w_down     = ELEM_DOWN[r_elem];
        w_op_end   = !ELEM_TWO_OPS[r_elem] || r_opi;
        w_addr_end = (r_addr == (w_down ? ADDR_FIRST : ADDR_LAST));
        w_seq_end  = w_op_end && w_addr_end && (r_elem == LAST_ELEM);

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state = RUN;
                    w_elem  = '0;
                    w_addr  = ADDR_FIRST;
                    w_opi   = 1'b0;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_clear = 1'b1;
                    w_issue = 1'b1;
                end
            end
            RUN: begin
                if (w_seq_end) begin
                    w_state = DRAIN;
                    w_drain = '0;
                end else begin
                    w_issue = 1'b1;
                    if (!w_op_end) begin
                        w_opi = 1'b1;
                    end else begin
                        w_opi = 1'b0;
                        if (w_addr_end) begin
                            w_elem = r_elem + 3'd1;
                            w_addr = ELEM_DOWN[r_elem + 3'd1] ? ADDR_LAST : ADDR_FIRST;
                        end else begin
                            w_addr = w_down ? r_addr - 1'b1 : r_addr + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                // Last read data is compared on the same edge that enters DONE.
                if (r_drain == DRAIN_LAST) begin
                    w_state = DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_drain = r_drain + 2'd1;
                end
            end
            default: w_state = IDLE;
        endcase

        w_op    = elem_op(w_elem, w_opi);
        w_write = w_issue && !op_is_read(w_op);
        w_read  = w_issue && op_is_read(w_op);
    end

    // Registered state and SRAM pins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_elem      <= '0;
            r_addr      <= '0;
            r_opi       <= 1'b0;
            r_drain     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_op        <= OP_W0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_oeb       <= 1'b1;
            r_data_oe   <= 1'b0;
            r_sram_addr <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_elem      <= w_elem;
            r_addr      <= w_addr;
            r_opi       <= w_opi;
            r_drain     <= w_drain;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_op        <= w_op;
            r_csb       <= !w_issue;
            r_web       <= !w_write;
            r_oeb       <= !w_read;
            r_data_oe   <= w_write;
            r_sram_addr <= w_issue ? w_addr : '0;
            r_wdata     <= w_write ? {DATA_WIDTH{op_value(w_op)}} : '0;
        end
    end

    assign w_rd_vld = !r_csb && !r_oeb;

    sram_bist_checker #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_rd_vld   (w_rd_vld),
        .i_rd_exp   ({DATA_WIDTH{op_value(r_op)}}),
        .i_rd_addr  (r_sram_addr),
        .i_rd_elem  (r_elem),
        .i_rdata    (sram_rdata),
        .o_fail     (fail),
        .o_fail_addr(fail_addr),
        .o_fail_elem(fail_elem),
        .o_fail_data(fail_data)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign sram_csb     = r_csb;
    assign sram_web     = r_web;
    assign sram_oeb     = r_oeb;
    assign sram_addr    = r_sram_addr;
    assign sram_wdata   = r_wdata;
    assign sram_data_oe = r_data_oe;

endmodule

// File: tb/tb_sram_march_bist.sv
module tb_sram_march_bist;

    localparam int AW = 4;
    localparam int DW = 2;
    localparam int N  = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst, start1, start2;

    logic          busy1, done1, fail1, csb1, web1, oeb1, doe1;
    logic [AW-1:0] faddr1, addr1;
    logic [2:0]    felem1;
    logic [DW-1:0] fdata1, wdata1, rdata1;

    logic          busy2, done2, fail2, csb2, web2, oeb2, doe2;
    logic [AW-1:0] faddr2, addr2;
    logic [2:0]    felem2;
    logic [DW-1:0] fdata2, wdata2, rdata2;

    sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .fail(fail1), .fail_addr(faddr1), .fail_elem(felem1), .fail_data(fdata1),
        .sram_csb(csb1), .sram_web(web1), .sram_oeb(oeb1), .sram_addr(addr1),
        .sram_wdata(wdata1), .sram_data_oe(doe1), .sram_rdata(rdata1)
    );

    sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .fail(fail2), .fail_addr(faddr2), .fail_elem(felem2), .fail_data(fdata2),
        .sram_csb(csb2), .sram_web(web2), .sram_oeb(oeb2), .sram_addr(addr2),
        .sram_wdata(wdata2), .sram_data_oe(doe2), .sram_rdata(rdata2)
    );

    // SRAM models: fm* is a stuck-at-0 bit mask applied to word fa*.
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem2 [N];
    logic [DW-1:0] rda1, rda2, rdb2;
    logic [AW-1:0] fa1, fa2;
    logic [DW-1:0] fm1, fm2;

    always @(posedge clk) begin
        if (!csb1 && !web1) mem1[addr1] <= wdata1 & ~((addr1 == fa1) ? fm1 : 2'b00);
        if (!csb1 && !oeb1) rda1 <= mem1[addr1];
        if (!csb2 && !web2) mem2[addr2] <= wdata2 & ~((addr2 == fa2) ? fm2 : 2'b00);
        if (!csb2 && !oeb2) rda2 <= mem2[addr2];
        rdb2 <= rda2;
    end
    assign rdata1 = rda1;
    assign rdata2 = rdb2;

    // Monitor mux: sel=0 watches dut1 (latency 1), sel=1 watches dut2 (latency 2).
    logic          sel;
    logic          m_busy, m_done, m_fail, m_csb, m_web, m_oeb, m_doe;
    logic [AW-1:0] m_faddr, m_addr;
    logic [2:0]    m_felem;
    logic [DW-1:0] m_fdata, m_wdata;
    assign m_busy  = sel ? busy2  : busy1;
    assign m_done  = sel ? done2  : done1;
    assign m_fail  = sel ? fail2  : fail1;
    assign m_faddr = sel ? faddr2 : faddr1;
    assign m_felem = sel ? felem2 : felem1;
    assign m_fdata = sel ? fdata2 : fdata1;
    assign m_csb   = sel ? csb2   : csb1;
    assign m_web   = sel ? web2   : web1;
    assign m_oeb   = sel ? oeb2   : oeb1;
    assign m_doe   = sel ? doe2   : doe1;
    assign m_addr  = sel ? addr2  : addr1;
    assign m_wdata = sel ? wdata2 : wdata1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   op_cnt, wr_cnt, first_op_cyc, done_cyc;

    // Reference March C- op list, pushed when a run is started.
    task automatic push_one(input int a, input logic wr, input logic v);
        exp_t e;
        e.addr = 4'(a);
        e.wr   = wr;
        e.data = {DW{v}};
        exp_q.push_back(e);
    endtask

    task automatic push_march();
        int a;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = (e == 3 || e == 4) ? (N - 1 - k) : k;
                case (e)
                    0: push_one(a, 1'b1, 1'b0);
                    1: begin push_one(a, 1'b0, 1'b0); push_one(a, 1'b1, 1'b1); end
                    2: begin push_one(a, 1'b0, 1'b1); push_one(a, 1'b1, 1'b0); end
                    3: begin push_one(a, 1'b0, 1'b0); push_one(a, 1'b1, 1'b1); end
                    4: begin push_one(a, 1'b0, 1'b1); push_one(a, 1'b1, 1'b0); end
                    default: push_one(a, 1'b0, 1'b0);
                endcase
            end
        end
    endtask

    // Scoreboard: every op cycle pops one expected op; idle cycles must show idle controls.
    task automatic monitor();
        exp_t       e;
        logic [8:0] got, want;
        forever begin
            @(negedge clk);
            if (!m_csb) begin
                op_cnt++;
                if (!m_web) wr_cnt++;
                if (first_op_cyc < 0) first_op_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL op_unexpected: op at addr %0d, scoreboard empty", m_addr);
                end else begin
                    e    = exp_q.pop_front();
                    want = {e.addr, !e.wr, e.wr, e.wr, (e.wr ? e.data : 2'b00)};
                    got  = {m_addr, m_web, m_oeb, m_doe, m_wdata};
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL op_seq #%0d {addr,web,oeb,oe,wdata}: got %h want %h", op_cnt, got, want);
                    end
                end
            end else begin
                n_checks++;
                if ({m_web, m_oeb, m_doe} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL idle_ctrl {web,oeb,oe}: got %b want 110", {m_web, m_oeb, m_doe});
                end
            end
        end
    endtask

    task automatic begin_run();
        op_cnt       = 0;
        wr_cnt       = 0;
        first_op_cyc = -1;
        push_march();
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) begin
                timed_out = 1'b0;
                done_cyc  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [17:0] exp_rst;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        // {busy,done,fail,faddr,felem,fdata,csb,web,oeb,oe,addr,wdata}
        exp_rst = {3'b000, 4'h0, 3'd0, 2'b00, 3'b111, 1'b0, 4'h0, 2'b00};
        n_checks++;
        if ({busy1, done1, fail1, faddr1, felem1, fdata1, csb1, web1, oeb1, doe1, addr1, wdata1} !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h want %h",
                     {busy1, done1, fail1, faddr1, felem1, fdata1, csb1, web1, oeb1, doe1, addr1, wdata1}, exp_rst);
        end
        n_checks++;
        if ({busy2, done2, fail2, faddr2, felem2, fdata2, csb2, web2, oeb2, doe2, addr2, wdata2} !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_dut2: got %h want %h",
                     {busy2, done2, fail2, faddr2, felem2, fdata2, csb2, web2, oeb2, doe2, addr2, wdata2}, exp_rst);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fault_free();
        bit to;
        sel = 1'b0;
        begin_run();
        n_checks++;
        if ({m_busy, m_csb, m_web, m_addr} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL first_op {busy,csb,web,addr}: got %b want 1000000", {m_busy, m_csb, m_web, m_addr});
        end
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL ff_done_timeout: got timeout want done"); end
        n_checks++;
        if (op_cnt !== 160) begin n_fail++; $display("FAIL ff_op_count: got %0d want 160", op_cnt); end
        n_checks++;
        if (wr_cnt !== 80) begin n_fail++; $display("FAIL ff_write_count: got %0d want 80", wr_cnt); end
        // Last op is 159 edges after the first; done follows READ_LATENCY+1 edges later
        // (the 162nd cycle when the first op cycle is counted as cycle 1).
        n_checks++;
        if (done_cyc - first_op_cyc !== 161) begin
            n_fail++;
            $display("FAIL ff_done_latency: got %0d want 161", done_cyc - first_op_cyc);
        end
        n_checks++;
        if ({m_fail, m_faddr, m_felem, m_fdata, m_busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL ff_fail_report: got %h want 0", {m_fail, m_faddr, m_felem, m_fdata, m_busy});
        end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ff_ops_missing: got %0d left want 0", exp_q.size()); end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_done, m_busy} !== 2'b10) begin n_fail++; $display("FAIL ff_done_hold: got %b want 10", {m_done, m_busy}); end
    endtask

    task automatic test_stuck_fault();
        bit to;
        sel = 1'b0;
        fa1 = 4'hC;
        fm1 = 2'b10;
        begin_run();
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL sf_done_timeout: got timeout want done"); end
        n_checks++;
        if ({m_fail, m_faddr, m_felem, m_fdata} !== {1'b1, 4'hC, 3'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL sf_report {fail,addr,elem,data}: got %h want %h",
                     {m_fail, m_faddr, m_felem, m_fdata}, {1'b1, 4'hC, 3'd2, 2'b01});
        end
        n_checks++;
        if (op_cnt !== 160) begin n_fail++; $display("FAIL sf_op_count: got %0d want 160", op_cnt); end
    endtask

    task automatic test_restart_from_done();
        bit to;
        sel = 1'b0;
        begin_run();
        n_checks++;
        if ({m_done, m_fail, m_busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL rs_clear {done,fail,busy}: got %b want 001", {m_done, m_fail, m_busy});
        end
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL rs_done_timeout: got timeout want done"); end
        n_checks++;
        if ({m_fail, m_faddr, m_felem, m_fdata} !== {1'b1, 4'hC, 3'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL rs_report: got %h want %h", {m_fail, m_faddr, m_felem, m_fdata}, {1'b1, 4'hC, 3'd2, 2'b01});
        end
        n_checks++;
        if (op_cnt !== 160) begin n_fail++; $display("FAIL rs_op_count: got %0d want 160", op_cnt); end
    endtask

    task automatic test_start_ignored();
        bit to;
        sel = 1'b0;
        fm1 = 2'b00;
        begin_run();
        repeat (40) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL si_done_timeout: got timeout want done"); end
        n_checks++;
        if (op_cnt !== 160) begin n_fail++; $display("FAIL si_op_count: got %0d want 160", op_cnt); end
        n_checks++;
        if ((exp_q.size() !== 0) || (m_fail !== 1'b0)) begin
            n_fail++;
            $display("FAIL si_result: got %0d left fail=%b want 0 left fail=0", exp_q.size(), m_fail);
        end
    endtask

    task automatic test_rst_midrun();
        bit to;
        sel = 1'b0;
        fa1 = 4'hC;
        fm1 = 2'b10;
        begin_run();
        for (int i = 0; i < 200 && op_cnt < 90; i++) @(negedge clk);
        n_checks++;
        if (op_cnt < 90) begin n_fail++; $display("FAIL rm_reach_e3: got %0d ops want >=90", op_cnt); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({csb1, web1, oeb1, doe1, busy1, done1, fail1} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL rm_reset_outputs {csb,web,oeb,oe,busy,done,fail}: got %b want 1110000",
                     {csb1, web1, oeb1, doe1, busy1, done1, fail1});
        end
        rst = 1'b0;
        exp_q.delete();
        fm1 = 2'b00;
        begin_run();
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL rm_done_timeout: got timeout want done"); end
        n_checks++;
        if ((op_cnt !== 160) || (m_fail !== 1'b0)) begin
            n_fail++;
            $display("FAIL rm_rerun: got ops=%0d fail=%b want ops=160 fail=0", op_cnt, m_fail);
        end
    endtask

    task automatic test_latency2();
        bit to;
        sel = 1'b1;
        begin_run();
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL l2_done_timeout: got timeout want done"); end
        n_checks++;
        if (done_cyc - first_op_cyc !== 162) begin
            n_fail++;
            $display("FAIL l2_done_latency: got %0d want 162", done_cyc - first_op_cyc);
        end
        n_checks++;
        if ((m_fail !== 1'b0) || (op_cnt !== 160)) begin
            n_fail++;
            $display("FAIL l2_clean: got fail=%b ops=%0d want fail=0 ops=160", m_fail, op_cnt);
        end
        fa2 = 4'h1;
        fm2 = 2'b10;
        begin_run();
        wait_done(to);
        n_checks++;
        if ({m_fail, m_faddr, m_felem, m_fdata} !== {1'b1, 4'h1, 3'd2, 2'b01}) begin
            n_fail++;
            $display("FAIL l2_fault_report: got %h want %h", {m_fail, m_faddr, m_felem, m_fdata}, {1'b1, 4'h1, 3'd2, 2'b01});
        end
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        sel    = 1'b0;
        fa1    = '0;
        fa2    = '0;
        fm1    = '0;
        fm2    = '0;
        op_cnt = 0;
        wr_cnt = 0;
        first_op_cyc = -1;
        done_cyc     = 0;
        test_reset();
        fork
            monitor();
        join_none
        test_fault_free();
        test_stuck_fault();
        test_restart_from_done();
        test_start_ignored();
        test_rst_midrun();
        test_latency2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
